// File: rtl/tff_mod_counter.sv
// tff_mod_counter: up/down modulo counter built as a bank of T flip-flops.
// A per-bit toggle vector is derived each cycle from the desired next value,
// and the register only ever updates by toggling: q <= q ^ t_vec.
// Supports programmable modulus, direction, parallel load (clamped into range),
// wrap or saturate at the range ends, a combinational terminal-count flag and
// a registered one-cycle range-end pulse.
module tff_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Largest legal count; with MOD == 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is representable for the load compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic             at_end;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t_vec;

  // Out-of-range load values are clamped to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
    return ({1'b0, val} < MOD_EXT) ? val : TOP;
  endfunction

  // Value taken when a count runs into a range end: hold or wrap around.
  function automatic logic [WIDTH-1:0] end_value(input logic [WIDTH-1:0] cur,
                                                 input logic             dir_up);
    if (SATURATE != 0)
      return cur;
    else
      return dir_up ? '0 : TOP;
  endfunction

  // Next-value selection (load > count > hold) and the resulting toggle vector.
  always_comb begin
    at_end = up ? (q == TOP) : (q == '0);
    nxt    = q;
    if (load)
      nxt = clamp_load(d);
    else if (en) begin
      if (at_end)
        nxt = end_value(q, up);
      else
        nxt = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    end
    t_vec = q ^ nxt;
  end

  assign tc = en & ~load & at_end;

  // T flip-flop bank plus range-end pulse; reset clears both and cancels a pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q ^ t_vec;
      wrap <= en & ~load & at_end;
    end
  end

endmodule
